// File: rtl/alu_seq_n_bits.sv
// Handshaked N-bit ALU with a registered result.
// Mul, udiv and urem run iteratively, one bit per cycle. All other ops finish in one cycle.
module alu_seq_n_bits #(
  parameter int unsigned N   = 32,
  parameter int unsigned SHW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [3:0]   ALUControl,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] RESULT,
  output logic [3:0]   flags
);

  localparam int unsigned CW  = $clog2(N);
  localparam int unsigned NP1 = N + 1;
  localparam int unsigned N2  = 2 * N;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_NOT = 4'b0101;
  localparam logic [3:0] OP_ASL = 4'b0110;
  localparam logic [3:0] OP_ASR = 4'b0111;
  localparam logic [3:0] OP_LSL = 4'b1000;
  localparam logic [3:0] OP_LSR = 4'b1001;
  localparam logic [3:0] OP_MUL = 4'b1010;
  localparam logic [3:0] OP_DIV = 4'b1011;
  localparam logic [3:0] OP_REM = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic [N-1:0]  result_q;
  logic [3:0]    flags_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    op_q;
  logic [N-1:0]  opnd_q;
  logic [N-1:0]  hi_q;
  logic [N-1:0]  lo_q;

  // Single-cycle datapath, evaluated on the live inputs in the accept cycle
  logic [SHW-1:0] sh_w;
  logic [N:0]     add_w;
  logic [N:0]     sub_w;
  logic [N2-1:0]  shl_w;
  logic [N:0]     shr_w;
  logic [N:0]     sar_w;
  logic [N-1:0]   sign_mask_w;

  assign sh_w        = B[SHW-1:0];
  assign add_w       = {1'b0, A} + {1'b0, B};
  assign sub_w       = {1'b0, A} + {1'b0, ~B} + NP1'(1);
  assign shl_w       = {N'(0), A} << sh_w;
  assign shr_w       = {A, 1'b0} >> sh_w;
  assign sar_w       = $unsigned($signed({A, 1'b0}) >>> sh_w);
  assign sign_mask_w = (N'(1) << sh_w) - N'(1);

  logic [N-1:0] res_d;
  logic [3:0]   flags_d;
  logic         c_w;
  logic         v_w;

  always_comb begin
    res_d = '0;
    c_w   = 1'b0;
    v_w   = 1'b0;
    case (ALUControl)
      OP_ADD: begin
        res_d = add_w[N-1:0];
        c_w   = add_w[N];
        v_w   = (A[N-1] == B[N-1]) && (add_w[N-1] != A[N-1]);
      end
      OP_SUB: begin
        res_d = sub_w[N-1:0];
        c_w   = sub_w[N];
        v_w   = (A[N-1] != B[N-1]) && (sub_w[N-1] != A[N-1]);
      end
      OP_AND: res_d = A & B;
      OP_OR:  res_d = A | B;
      OP_XOR: res_d = A ^ B;
      OP_NOT: res_d = ~A;
      // Overflow when any bit pushed out, or the new sign, disagrees with the old sign
      OP_ASL: begin
        res_d = shl_w[N-1:0];
        c_w   = shl_w[N];
        v_w   = (shl_w[N2-1:N] != (A[N-1] ? sign_mask_w : '0)) ||
                (shl_w[N-1] != A[N-1]);
      end
      OP_LSL: begin
        res_d = shl_w[N-1:0];
        c_w   = shl_w[N];
      end
      OP_ASR: begin
        res_d = sar_w[N:1];
        c_w   = sar_w[0];
      end
      OP_LSR: begin
        res_d = shr_w[N:1];
        c_w   = shr_w[0];
      end
      default: res_d = '0;
    endcase
    flags_d = {res_d == '0, res_d[N-1], c_w, v_w};
  end

  // One iteration: mul adds then shifts {hi,lo} right; div shifts left then tries a subtract
  logic [N:0]   mul_sum_w;
  logic [N:0]   div_sh_w;
  logic [N-1:0] div_diff_w;
  logic         div_ok_w;
  logic [N-1:0] hi_d;
  logic [N-1:0] lo_d;

  assign mul_sum_w  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_sh_w   = {hi_q, lo_q[N-1]};
  assign div_ok_w   = div_sh_w >= {1'b0, opnd_q};
  assign div_diff_w = div_sh_w[N-1:0] - opnd_q;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (op_q == OP_MUL) begin
      hi_d = mul_sum_w[N:1];
      lo_d = {mul_sum_w[0], lo_q[N-1:1]};
    end else begin
      hi_d = div_ok_w ? div_diff_w : div_sh_w[N-1:0];
      lo_d = {lo_q[N-2:0], div_ok_w};
    end
  end

  logic [N-1:0] it_res_d;
  logic [3:0]   it_flags_d;

  always_comb begin
    it_res_d   = (op_q == OP_REM) ? hi_d : lo_d;
    it_flags_d = {it_res_d == '0, it_res_d[N-1],
                  (op_q == OP_MUL) && (hi_d != '0),
                  (op_q != OP_MUL) && (opnd_q == '0)};
  end

  // Control FSM; reset takes priority over any in-flight operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      cnt_q       <= '0;
      op_q        <= '0;
      opnd_q      <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_q       <= ALUControl;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            if (ALUControl == OP_MUL) begin
              state_q <= S_EXEC;
              opnd_q  <= A;
              hi_q    <= '0;
              lo_q    <= B;
            end else if (ALUControl == OP_DIV || ALUControl == OP_REM) begin
              state_q <= S_EXEC;
              opnd_q  <= B;
              hi_q    <= '0;
              lo_q    <= A;
            end else begin
              state_q     <= S_DONE;
              result_q    <= res_d;
              flags_q     <= flags_d;
              out_valid_q <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            state_q     <= S_DONE;
            result_q    <= it_res_d;
            flags_q     <= it_flags_d;
            out_valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign RESULT    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_seq_n_bits.sv
// Self-checking bench for alu_seq_n_bits (N=32): directed scenarios plus random ops vs a behavioural model.
module tb_alu_seq_n_bits;

  localparam int unsigned N = 32;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [3:0]   ALUControl;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] RESULT;
  logic [3:0]   flags;

  int n_vec = 0;
  int n_err = 0;

  alu_seq_n_bits #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .ALUControl (ALUControl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .RESULT     (RESULT),
    .flags      (flags)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model from the opcode rules, using wide integer arithmetic
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [3:0] f, output int lat);
    longint unsigned ua, ub, p;
    longint sa, sb, t;
    int sh;
    logic c, v;
    ua = a; ub = b;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b[4:0]);
    c = 1'b0; v = 1'b0; lat = 1; r = '0;
    case (op)
      4'd0: begin p = ua + ub; r = p[31:0]; c = p[32]; t = sa + sb; v = (t != longint'(int'(t))); end
      4'd1: begin r = a - b; c = (a >= b); t = sa - sb; v = (t != longint'(int'(t))); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: begin
        r = a << sh; c = (sh == 0) ? 1'b0 : a[32 - sh];
        t = sa <<< sh; v = (t != longint'(int'(t)));
      end
      4'd7: begin r = $signed(a) >>> sh; c = (sh == 0) ? 1'b0 : a[sh - 1]; end
      4'd8: begin r = a << sh; c = (sh == 0) ? 1'b0 : a[32 - sh]; end
      4'd9: begin r = a >> sh; c = (sh == 0) ? 1'b0 : a[sh - 1]; end
      4'd10: begin p = ua * ub; r = p[31:0]; c = (p[63:32] != 0); lat = N + 1; end
      4'd11: begin
        lat = N + 1;
        if (b == 0) begin r = '1; v = 1'b1; end else r = a / b;
      end
      4'd12: begin
        lat = N + 1;
        if (b == 0) begin r = a; v = 1'b1; end else r = a % b;
      end
      default: r = '0;
    endcase
    f = {r == 0, r[31], c, v};
  endfunction

  // Drive one operation, scramble inputs after accept, wait (bounded) for out_valid
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic [3:0] f, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 200) begin @(posedge clk); #1; guard++; end
    in_valid = 1'b1; A = a; B = b; ALUControl = op;
    @(posedge clk); #1;
    in_valid = 1'b0; A = $urandom; B = $urandom; ALUControl = 4'($urandom_range(0, 15));
    lat = 1;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    r = RESULT; f = flags;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; ALUControl = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_vec++; if (RESULT !== 32'h0) begin n_err++; $display("FAIL reset_result got %h exp 0", RESULT); end
    n_vec++; if (flags !== 4'b0) begin n_err++; $display("FAIL reset_flags got %b exp 0000", flags); end
  endtask

  task automatic test_add_overflow();
    logic [31:0] r; logic [3:0] f; int lat;
    issue(4'b0000, 32'h7FFF_FFFF, 32'h1, r, f, lat);
    n_vec++; if (lat !== 1) begin n_err++; $display("FAIL add_latency got %0d exp 1", lat); end
    n_vec++; if (r !== 32'h8000_0000) begin n_err++; $display("FAIL add_result got %h exp 80000000", r); end
    n_vec++; if (f !== 4'b0101) begin n_err++; $display("FAIL add_flags got %b exp 0101", f); end
    release_out();
  endtask

  task automatic test_reset_mid_exec();
    in_valid = 1'b1; A = 32'd5; B = 32'd7; ALUControl = 4'b1010;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL exec_in_ready got %b exp 0", in_ready); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_exec_in_ready got %b exp 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_exec_out_valid got %b exp 0", out_valid); end
    n_vec++; if (RESULT !== 32'h0) begin n_err++; $display("FAIL rst_exec_result got %h exp 0", RESULT); end
    n_vec++; if (flags !== 4'b0) begin n_err++; $display("FAIL rst_exec_flags got %b exp 0000", flags); end
  endtask

  task automatic test_sub_equal();
    logic [31:0] r; logic [3:0] f; int lat;
    issue(4'b0001, 32'h1234, 32'h1234, r, f, lat);
    n_vec++; if (r !== 32'h0) begin n_err++; $display("FAIL sub_result got %h exp 0", r); end
    n_vec++; if (f !== 4'b1010) begin n_err++; $display("FAIL sub_flags got %b exp 1010", f); end
    release_out();
  endtask

  task automatic test_mul();
    logic [31:0] r; logic [3:0] f; int lat;
    issue(4'b1010, 32'h0001_0000, 32'h0001_0000, r, f, lat);
    n_vec++; if (lat !== 33) begin n_err++; $display("FAIL mul_latency got %0d exp 33", lat); end
    n_vec++; if (r !== 32'h0) begin n_err++; $display("FAIL mul_result got %h exp 0", r); end
    n_vec++; if (f !== 4'b1010) begin n_err++; $display("FAIL mul_flags got %b exp 1010", f); end
    release_out();
  endtask

  task automatic test_div_rem();
    logic [31:0] r; logic [3:0] f; int lat;
    logic [3:0]  ops [4] = '{4'b1011, 4'b1100, 4'b1011, 4'b1100};
    logic [31:0] as  [4] = '{32'd100, 32'd100, 32'd9, 32'd9};
    logic [31:0] bs  [4] = '{32'd7, 32'd7, 32'd0, 32'd0};
    logic [31:0] er  [4] = '{32'd14, 32'd2, 32'hFFFF_FFFF, 32'd9};
    logic [3:0]  ef  [4] = '{4'b0000, 4'b0000, 4'b0101, 4'b0001};
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i], r, f, lat);
      n_vec++; if (r !== er[i]) begin n_err++; $display("FAIL divrem_result[%0d] got %h exp %h", i, r, er[i]); end
      n_vec++; if (f !== ef[i]) begin n_err++; $display("FAIL divrem_flags[%0d] got %b exp %b", i, f, ef[i]); end
      n_vec++; if (lat !== 33) begin n_err++; $display("FAIL divrem_latency[%0d] got %0d exp 33", i, lat); end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] r; logic [3:0] f; int lat;
    issue(4'b0111, 32'h8000_0000, 32'd4, r, f, lat);
    n_vec++; if (r !== 32'hF800_0000) begin n_err++; $display("FAIL asr_result got %h exp f8000000", r); end
    n_vec++; if (f !== 4'b0100) begin n_err++; $display("FAIL asr_flags got %b exp 0100", f); end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; A = $urandom; B = $urandom; ALUControl = 4'b0000;
      @(posedge clk); #1;
      n_vec++; if (RESULT !== 32'hF800_0000) begin n_err++; $display("FAIL stall_result[%0d] got %h exp f8000000", i, RESULT); end
      n_vec++; if (flags !== 4'b0100) begin n_err++; $display("FAIL stall_flags[%0d] got %b exp 0100", i, flags); end
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready[%0d] got %b exp 0", i, in_ready); end
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_out_valid[%0d] got %b exp 1", i, out_valid); end
    end
    in_valid = 1'b1; A = 32'd1; B = 32'd1; ALUControl = 4'b0000;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL release_out_valid got %b exp 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL release_in_ready got %b exp 1", in_ready); end
    @(posedge clk); #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL release_no_accept got %b exp 0", out_valid); end
  endtask

  task automatic test_lsr();
    logic [31:0] r; logic [3:0] f; int lat;
    issue(4'b1001, 32'd3, 32'd1, r, f, lat);
    n_vec++; if (r !== 32'd1) begin n_err++; $display("FAIL lsr_result got %h exp 1", r); end
    n_vec++; if (f !== 4'b0010) begin n_err++; $display("FAIL lsr_flags got %b exp 0010", f); end
    release_out();
  endtask

  task automatic test_random();
    logic [31:0] r, a, b, er; logic [3:0] f, ef, op; int lat, el;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 40));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 1000));
      model(op, a, b, er, ef, el);
      issue(op, a, b, r, f, lat);
      n_vec++; if (r !== er) begin n_err++; $display("FAIL rand_result op=%h a=%h b=%h got %h exp %h", op, a, b, r, er); end
      n_vec++; if (f !== ef) begin n_err++; $display("FAIL rand_flags op=%h a=%h b=%h got %b exp %b", op, a, b, f, ef); end
      n_vec++; if (lat !== el) begin n_err++; $display("FAIL rand_latency op=%h got %0d exp %0d", op, lat, el); end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      release_out();
    end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_reset_mid_exec();
    test_sub_equal();
    test_mul();
    test_div_rem();
    test_backpressure();
    test_lsr();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq_n_bits.md
Name: alu_seq_n_bits

Overview:
- Parametrised, handshaked successor to the combinational N-bit ALU.
- Keeps the same opcode map and flag order (Z N C V). Adds variable shift amounts, an iterative multiplier, an unsigned divider/remainder, and a registered result.
- Sits between operand fetch and writeback. Operands enter through a valid/ready handshake. The result and flags are held until the consumer accepts them.

Parameters:
- N, 32, operand/result width (N >= 4).
- SHW, $clog2(N), width of the shift-amount field taken from B[SHW-1:0].

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands/opcode valid.
- in_ready  out  1  block can accept a new operation.
- A  in  N  operand A.
- B  in  N  operand B (shift amount in B[SHW-1:0] for shifts).
- ALUControl  in  4  opcode.
- out_valid  out  1  RESULT/flags valid.
- out_ready  in  1  consumer accepts result.
- RESULT  out  N  registered result.
- flags  out  4  registered {Z,N,C,V}.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, in_ready=1, out_valid=0, RESULT=0, flags=0, iteration counter=0. Reset wins over every other event, including mid-EXEC and mid-DONE.
- Opcodes:
  - 0000 add; 0001 sub (A+~B+1); 0010 and; 0011 or; 0100 xor; 0101 not A.
  - 0110 arith shift left A by B[SHW-1:0]; 0111 arith shift right (sign fill); 1000 logical shift left; 1001 logical shift right.
  - 1010 mul: low N bits of unsigned A*B. 1011 udiv quotient. 1100 urem remainder.
  - 1101-1111 reserved: RESULT=0, flags=4'b1000.
- FSM states IDLE, EXEC, DONE:
  - IDLE: in_ready=1. On in_valid, latch A, B, opcode. Single-cycle ops go to DONE next cycle with RESULT/flags loaded (latency 1). Mul/div/rem go to EXEC, counter=0.
  - EXEC: in_ready=0. One shift-add (mul) or restoring shift-subtract (div/rem) step per cycle. After exactly N steps go to DONE (latency N+1 from accept).
  - DONE: out_valid=1, in_ready=0. RESULT/flags are stable while out_ready=0. On out_ready=1 go to IDLE next cycle; out_valid drops in that cycle. No accept occurs in the same cycle as the DONE->IDLE transition.
- Inputs A/B/ALUControl are ignored outside the accept cycle. Changing them during EXEC/DONE has no effect.
- Flags are computed on the final result:
  - Z: RESULT==0. N: RESULT[N-1].
  - C, add: carry out. C, sub: carry out of A+~B+1 (1 = no borrow, A>=B unsigned).
  - C, shifts: last bit shifted out; 0 when amount=0. C, mul: 1 if the upper N bits of the full product are non-zero. C is 0 for logic/div/rem.
  - V, add/sub: signed overflow. V, div/rem: 1 on divide by zero. V=0 otherwise.
- Divide by zero (B=0): still takes N+1 cycles. Quotient=all ones, remainder=A, V=1.
- Shift amount 0 passes A unchanged. An amount equal to N is impossible (SHW bits).
- The arithmetic left shift equals the logical left shift in result. For 0110 only, V=1 if any shifted-out bit or the result sign differs from A[N-1].

Test Plan:
1. Reset mid-EXEC: accept mul A=5, B=7, assert rst at cycle 3 -> next cycle in_ready=1, out_valid=0, RESULT=0, flags=0.
2. Add overflow: A=32'h7FFFFFFF, B=1, op 0000 -> out_valid at cycle 1; RESULT=32'h80000000, flags=4'b0101 (N,V).
3. Sub equal: A=B=32'h1234, op 0001 -> RESULT=0, flags=4'b1010 (Z,C).
4. Mul: A=32'h00010000, B=32'h00010000, op 1010 -> out_valid exactly 33 cycles after accept; RESULT=0, flags=4'b1010 (Z, C for a non-zero high word).
5. Div and rem: A=100, B=7, op 1011 -> RESULT=14, flags=0. Op 1100 -> RESULT=2. Div by zero: A=9, B=0, op 1011 -> RESULT=32'hFFFFFFFF, flags=4'b0101. Op 1100 -> RESULT=9, flags=4'b0001.
6. Backpressure and shifts:
   - Op 0111, A=32'h80000000, B=4 with out_ready=0 for 5 cycles -> RESULT=32'hF8000000, flags=4'b0100, stable while stalled, in_ready=0. Release -> out_valid=0 and in_ready=1 next cycle. A new in_valid in the release cycle is not accepted.
   - Op 1001, A=3, B=1 -> RESULT=1, C=1.
